pong_engine: RTL

Parametrised game-dynamics engine for the screen-pong game; successor of the fixed frame-clocked dynamics block. Runs on the pixel clock. Advances one game step per endframe strobe. Provides:
- Configurable screen geometry, paddle size and ball size.
- Speed-up on rally, win score and serve delay.
- Scores, winner flag, goal pulses and sound codes for the scoreboard and sound card.

---
 rtl/pong_engine_pkg.sv | 19 +
 rtl/pong_sound_timer.sv | 35 +++
 rtl/pong_engine.sv | 185 ++++++++++++++++++
 3 files changed

// File: rtl/pong_engine_pkg.sv
// pong_engine_pkg: shared state, sound and winner encodings for the pong engine
package pong_engine_pkg;
    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        SERVE    = 3'd1,
        PLAY     = 3'd2,
        GOAL     = 3'd3,
        GAMEOVER = 3'd4
    } state_t;

    localparam logic [1:0] SND_NONE = 2'b00;
    localparam logic [1:0] SND_WALL = 2'b01;
    localparam logic [1:0] SND_PAD  = 2'b10;
    localparam logic [1:0] SND_GOAL = 2'b11;

    localparam logic [1:0] WIN_NONE = 2'b00;
    localparam logic [1:0] WIN_P1   = 2'b01;
    localparam logic [1:0] WIN_P2   = 2'b10;
endpackage

// File: rtl/pong_sound_timer.sv
// pong_sound_timer: holds the latest sound event code for SND_FRAMES frames
module pong_sound_timer
    import pong_engine_pkg::*;
#(
    parameter int SND_FRAMES = 6
) (
    input  logic       px_clk,
    input  logic       reset,
    input  logic       endframe,
    input  logic [1:0] ev,
    output logic [1:0] sound,
    output logic       mute
);
    localparam int TW = $clog2(SND_FRAMES + 1);

    logic [TW-1:0] timer;

    always_ff @(posedge px_clk) begin
        if (reset) begin
            sound <= SND_NONE;
            timer <= '0;
        end else if (endframe) begin
            if (ev != SND_NONE) begin
                sound <= ev;
                timer <= TW'(SND_FRAMES);
            end else if (timer != '0) begin
                timer <= timer - TW'(1);
                if (timer == TW'(1))
                    sound <= SND_NONE;
            end
        end
    end

    assign mute = sound == SND_NONE;
endmodule

// File: rtl/pong_engine.sv
// pong_engine: frame-stepped pong dynamics with serve delay, rally speed-up,
// scoring and sound events; advances one step per endframe strobe.
module pong_engine
    import pong_engine_pkg::*;
#(
    parameter int H_RES          = 640,
    parameter int V_RES          = 480,
    parameter int PW             = 10,
    parameter int BALL_SIZE      = 8,
    parameter int PAD_H          = 64,
    parameter int PAD_W          = 8,
    parameter int PAD1_X         = 16,
    parameter int PAD2_X         = 616,
    parameter int SPEED_INIT     = 2,
    parameter int SPEED_MAX      = 6,
    parameter int HITS_PER_SPEED = 4,
    parameter int WIN_SCORE      = 9,
    parameter int SERVE_FRAMES   = 60,
    parameter int SND_FRAMES     = 6
) (
    input  logic          px_clk,
    input  logic          reset,
    input  logic          endframe,
    input  logic          play,
    input  logic [PW-1:0] pos_ply1,
    input  logic [PW-1:0] pos_ply2,
    output logic [PW-1:0] x_ball,
    output logic [PW-1:0] y_ball,
    output logic          goal_ply1,
    output logic          goal_ply2,
    output logic [3:0]    score1,
    output logic [3:0]    score2,
    output logic [1:0]    winner,
    output logic [1:0]    sound,
    output logic          mute,
    output logic [2:0]    state
);
    localparam int SW = PW + 2;
    localparam int CW = $clog2(SERVE_FRAMES + 1);
    localparam int HW = $clog2(HITS_PER_SPEED + 1);
    localparam logic signed [SW-1:0] ZERO  = '0;
    localparam logic signed [SW-1:0] ONE   = SW'(1);
    localparam logic signed [SW-1:0] BS    = SW'(BALL_SIZE);
    localparam logic signed [SW-1:0] HR    = SW'(H_RES);
    localparam logic signed [SW-1:0] VR    = SW'(V_RES);
    localparam logic signed [SW-1:0] PH    = SW'(PAD_H);
    localparam logic signed [SW-1:0] P1L   = SW'(PAD1_X);
    localparam logic signed [SW-1:0] P1R   = SW'(PAD1_X + PAD_W);
    localparam logic signed [SW-1:0] P2L   = SW'(PAD2_X);
    localparam logic signed [SW-1:0] P2R   = SW'(PAD2_X + PAD_W);
    localparam logic signed [SW-1:0] SINIT = SW'(SPEED_INIT);
    localparam logic signed [SW-1:0] SMAX  = SW'(SPEED_MAX);
    localparam logic [PW-1:0] XC  = PW'((H_RES - BALL_SIZE) / 2);
    localparam logic [PW-1:0] YC  = PW'((V_RES - BALL_SIZE) / 2);
    localparam logic [3:0]    WIN = 4'(WIN_SCORE);

    state_t st, st_n;
    logic signed [SW-1:0] dx, dy, spd, xn, yn, p1, p2, dx_n, dy_n, dy_mag, spd_n;
    logic [PW-1:0] x_n, y_n;
    logic [CW-1:0] serve_cnt;
    logic [HW-1:0] hit_cnt, hc_inc, hit_cnt_n;
    logic serve_right, dy_down, down_n, top, bot, hit1, hit2, hit, bump, g1, g2;
    logic [1:0] ev;

    // Candidate PLAY step: move, then resolve walls, paddles and goals on the new position
    always_comb begin
        xn        = $signed({2'b00, x_ball}) + dx;
        yn        = $signed({2'b00, y_ball}) + dy;
        p1        = $signed({2'b00, pos_ply1});
        p2        = $signed({2'b00, pos_ply2});
        top       = yn < ZERO;
        bot       = yn + BS > VR;
        hit1      = dx < ZERO && xn <= P1R && xn + BS > P1L && yn + BS > p1 && yn < p1 + PH;
        hit2      = dx > ZERO && xn + BS >= P2L && xn < P2R && yn + BS > p2 && yn < p2 + PH;
        hit       = hit1 || hit2;
        g2        = !hit && xn <= ZERO;
        g1        = !hit && xn + BS >= HR;
        hc_inc    = hit_cnt + HW'(1);
        bump      = hit && hc_inc == HW'(HITS_PER_SPEED);
        spd_n     = bump && spd < SMAX ? spd + ONE : spd;
        hit_cnt_n = !hit ? hit_cnt : bump ? '0 : hc_inc;
        down_n    = top ? 1'b1 : bot ? 1'b0 : dy > ZERO;
        dy_mag    = hit ? spd_n : dy < ZERO ? -dy : dy;
        dy_n      = down_n ? dy_mag : -dy_mag;
        dx_n      = hit1 ? spd_n : hit2 ? -spd_n : dx;
        y_n       = top ? '0 : bot ? PW'(V_RES - BALL_SIZE) : yn[PW-1:0];
        x_n       = hit1 ? PW'(PAD1_X + PAD_W) : hit2 ? PW'(PAD2_X - BALL_SIZE) :
                    g2 ? '0 : g1 ? PW'(H_RES - BALL_SIZE) : xn[PW-1:0];
    end

    always_ff @(posedge px_clk) begin
        if (reset)
            st <= IDLE;
        else if (endframe)
            st <= st_n;
    end

    always_comb begin
        st_n = st;
        case (st)
            IDLE, GAMEOVER: st_n = play ? SERVE : st;
            SERVE:          st_n = serve_cnt <= CW'(1) ? PLAY : SERVE;
            PLAY:           st_n = g1 || g2 ? GOAL : PLAY;
            GOAL:           st_n = score1 == WIN || score2 == WIN ? GAMEOVER : SERVE;
            default:        st_n = IDLE;
        endcase
    end

    always_comb begin
        ev    = st != PLAY ? SND_NONE : g1 || g2 ? SND_GOAL : hit ? SND_PAD :
                top || bot ? SND_WALL : SND_NONE;
        state = st;
    end

    always_ff @(posedge px_clk) begin
        if (reset) begin
            x_ball      <= XC;
            y_ball      <= YC;
            dx          <= ZERO;
            dy          <= ZERO;
            spd         <= SINIT;
            hit_cnt     <= '0;
            serve_cnt   <= '0;
            serve_right <= 1'b1;
            dy_down     <= 1'b1;
            score1      <= '0;
            score2      <= '0;
            winner      <= WIN_NONE;
            goal_ply1   <= 1'b0;
            goal_ply2   <= 1'b0;
        end else if (endframe) begin
            goal_ply1 <= 1'b0;
            goal_ply2 <= 1'b0;
            if (st == PLAY) begin
                x_ball  <= x_n;
                y_ball  <= y_n;
                dx      <= dx_n;
                dy      <= dy_n;
                spd     <= spd_n;
                hit_cnt <= hit_cnt_n;
                if (g1) begin
                    score1      <= score1 == WIN ? score1 : score1 + 4'd1;
                    goal_ply1   <= 1'b1;
                    serve_right <= 1'b1;
                end
                if (g2) begin
                    score2      <= score2 == WIN ? score2 : score2 + 4'd1;
                    goal_ply2   <= 1'b1;
                    serve_right <= 1'b0;
                end
            end else begin
                x_ball <= XC;
                y_ball <= YC;
            end
            if (st == SERVE)
                serve_cnt <= serve_cnt - CW'(1);
            if (st_n == SERVE && st != SERVE) begin
                serve_cnt <= CW'(SERVE_FRAMES);
                spd       <= SINIT;
                hit_cnt   <= '0;
            end
            if (st == SERVE && st_n == PLAY) begin
                dx      <= serve_right ? spd : -spd;
                dy      <= dy_down ? spd : -spd;
                dy_down <= !dy_down;
            end
            if (st == GOAL && st_n == GAMEOVER)
                winner <= score1 == WIN ? WIN_P1 : WIN_P2;
            if (st == GAMEOVER && play) begin
                score1 <= '0;
                score2 <= '0;
                winner <= WIN_NONE;
            end
        end
    end

    pong_sound_timer #(.SND_FRAMES(SND_FRAMES)) u_sound (
        .px_clk  (px_clk),
        .reset   (reset),
        .endframe(endframe),
        .ev      (ev),
        .sound   (sound),
        .mute    (mute)
    );
endmodule
